// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
//   Frame controller for an external serial-in/parallel-out shift register.
//   A one-cycle start clears the SIPO and begins a frame; WIDTH qualified
//   bits are shifted (MSB first), an optional even-parity bit is checked,
//   and the resulting word is presented on a valid/ready output register.
//
// Ports
//   clk        : single clock, rising edge
//   clear_n    : synchronous active-low reset
//   start      : frame-start request (honoured in IDLE only)
//   si         : serial data bit
//   bit_en     : qualifies si this cycle
//   po_in      : parallel output of the external SIPO
//   sipo_clr   : active-high clear to the SIPO (combinational)
//   shift_en   : shift enable to the SIPO (combinational)
//   busy       : frame in progress
//   bit_cnt    : data bits shifted in the current frame
//   out_data   : captured word
//   out_valid  : out_data holds an unaccepted word
//   out_ready  : consumer accepts the word
//   parity_err : parity result for out_data (0 when PARITY_EN=0)
//   overrun    : sticky, a completed word was dropped
//   clr_err    : clears overrun
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | shifting data bits into the SIPO
// PARITY | waiting for the parity bit
// LOAD   | transferring the SIPO word to the output register

module sipo_frame_ctrl #(
    parameter int WIDTH     = 9,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic                       start,
    input  logic                       si,
    input  logic                       bit_en,
    input  logic [WIDTH-1:0]           po_in,
    output logic                       sipo_clr,
    output logic                       shift_en,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       parity_err,
    output logic                       overrun,
    input  logic                       clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        perr_d       = perr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        sipo_clr     = 1'b0;
        shift_en     = 1'b0;

        // Consumer handshake; a LOAD on the same edge overrides below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear first so that a same-edge overrun set wins.
        if (clr_err) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    sipo_clr  = 1'b1;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                end
            end
            SHIFT: begin
                shift_en = bit_en;
                if (bit_en) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? PARITY : LOAD;
                    end
                end
            end
            PARITY: begin
                // po_in already holds the full data word; si is the parity bit.
                if (bit_en) begin
                    perr_d  = PARITY_EN ? ^{po_in, si} : 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!out_valid_q || out_ready) begin
                    out_data_d   = po_in;
                    parity_err_d = perr_q;
                    out_valid_d  = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold the SIPO cleared and frozen while in reset.
        if (!clear_n) begin
            sipo_clr = 1'b1;
            shift_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            perr_q       <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            perr_q       <= perr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign bit_cnt    = bit_cnt_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 9, giving the SIPO word width in bits (range 2..32).
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 = one even-parity bit follows the data bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port clear_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame-start request.
REQ-006 SHALL have port si  input  1  serial data bit, MSB first.
REQ-007 SHALL have port bit_en  input  1  qualifies si on this cycle.
REQ-008 SHALL have port po_in  input  WIDTH  parallel output of the external SIPO.
REQ-009 SHALL have port sipo_clr  output  1  active-high clear to the SIPO.
REQ-010 SHALL have port shift_en  output  1  shift enable to the SIPO.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port bit_cnt  output  $clog2(WIDTH+1)  data bits shifted in the current frame.
REQ-013 SHALL have port out_data  output  WIDTH  captured word.
REQ-014 SHALL have port out_valid  output  1  out_data holds an unaccepted word.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-016 SHALL have port parity_err  output  1  parity result for out_data (0 when PARITY_EN=0).
REQ-017 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-018 SHALL have port clr_err  input  1  clears overrun.

Function
REQ-019 SHALL implement the states IDLE, SHIFT, PARITY and LOAD.
REQ-020 IDLE & start SHALL move to SHIFT, assert sipo_clr (combinational) in that cycle, and zero bit_cnt.
REQ-021 shift_en SHALL equal (state==SHIFT) & bit_en, combinationally, so the SIPO shifts on the same edge.
REQ-022 In SHIFT, each bit_en edge SHALL increment bit_cnt; bit_en=0 cycles SHALL stall without a timeout.
REQ-023 On the edge where bit_cnt reaches WIDTH, SHIFT SHALL go to PARITY if PARITY_EN=1, else to LOAD.
REQ-024 PARITY SHALL wait for bit_en, then latch perr = ^{po_in, si} and go to LOAD; shift_en SHALL stay 0 in PARITY.
REQ-025 In LOAD, if out_valid=0 or out_ready=1, the block SHALL register out_data<=po_in, parity_err<=perr and out_valid<=1.
REQ-026 In LOAD, if out_valid=1 and out_ready=0, the block SHALL keep the old word and set overrun.
REQ-027 LOAD SHALL always return to IDLE after one cycle.
REQ-028 out_valid & out_ready SHALL clear out_valid on that edge, unless REQ-025 reloads it on the same edge.
REQ-029 busy SHALL be 1 in SHIFT, PARITY and LOAD.
REQ-030 start SHALL be ignored when the state is not IDLE.
REQ-031 clr_err SHALL clear overrun; if set and clear coincide, set SHALL win.
REQ-032 Latency with bit_en held high SHALL be: start edge E0, shifts on E1..E(WIDTH), out_valid high after E(WIDTH+1); add 1 edge when PARITY_EN=1.

Reset
REQ-033 clear_n=0 on a rising edge SHALL force IDLE, bit_cnt=0, out_data=0, out_valid=0, parity_err=0 and overrun=0, including mid-frame.
REQ-034 While in reset, sipo_clr SHALL be 1 and shift_en SHALL be 0.

Verification
REQ-035 WIDTH=9: start, then bits 1,0,1,1,0,0,1,1,1 with bit_en=1 -> out_data=9'b101100111 and out_valid=1 after E10; shift_en high exactly 9 cycles.
REQ-036 Same frame with bit_en toggling 1,0 -> 9 shifts only, bit_cnt stalls on the 0 cycles, out_data unchanged.
REQ-037 Two frames with out_ready=0 -> first word retained and overrun=1; clr_err -> overrun=0.
REQ-038 PARITY_EN=1, data 9'b101100111 with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1.
REQ-039 clear_n=0 after 4 data bits -> state IDLE and bit_cnt=0; new frame 9'b000000001 -> out_data=9'b000000001.
REQ-040 start pulse during SHIFT -> no restart, sipo_clr stays 0, frame completes normally.
